// File: rtl/odd_chk_pkg.sv
// rtl/odd_chk_pkg.sv - shared types, constants and next-value rule for the odd sequence checker
package odd_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int CNT_W = 8;
    localparam int STEP  = 2;
    localparam logic [CNT_W-1:0] MAX_ODD = 8'd255;

    // Wraps modulo 256, so 255 steps to 1 and odd values stay odd.
    function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] v);
        return v + CNT_W'(STEP);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - parameterised saturating counter; clr is applied before inc in the same cycle
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(inc);
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/odd_seq_checker.sv
// rtl/odd_seq_checker.sv - monitor that locks onto the odd count sequence and tracks mismatches
// Optional wrap_cnt_o output is built when ODD_CHK_WRAP_CNT_EN is defined.
module odd_seq_checker
    import odd_chk_pkg::*;
#(
    parameter int LOCK_N   = 4,
    parameter int MISS_MAX = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       cnt_i,
    input  logic             clr,
    output logic             locked_o,
    output logic             err_o,
    output logic             sticky_err_o,
    output logic [ERR_W-1:0] err_cnt_o,
`ifdef ODD_CHK_WRAP_CNT_EN
    output logic [7:0]       wrap_cnt_o,
`endif
    output logic [7:0]       exp_o
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);
    localparam logic [3:0] MISS_LAST = 4'(MISS_MAX - 1);

    state_t     state;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;
    logic       hit;
    logic       err_evt;

    assign hit     = (cnt_i == exp_o);
    assign err_evt = en && (state == LOCK) && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            exp_o        <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
            sticky_err_o <= 1'b0;
        end else begin
            err_o <= err_evt;
            if (clr) begin
                sticky_err_o <= err_evt;
            end else if (err_evt) begin
                sticky_err_o <= 1'b1;
            end
            if (en) begin
                case (state)
                    IDLE: begin
                        if (cnt_i[0]) begin
                            state     <= ACQ;
                            exp_o     <= nxt(cnt_i);
                            match_cnt <= '0;
                        end
                    end
                    ACQ: begin
                        if (hit) begin
                            exp_o <= nxt(exp_o);
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCK;
                                locked_o  <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else if (cnt_i[0]) begin
                            exp_o     <= nxt(cnt_i);
                            match_cnt <= '0;
                        end else begin
                            state     <= IDLE;
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        // Flywheel: the expectation advances even on a bad sample.
                        exp_o <= nxt(exp_o);
                        if (hit) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == MISS_LAST) begin
                            state    <= IDLE;
                            locked_o <= 1'b0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_evt),
        .cnt (err_cnt_o)
    );

`ifdef ODD_CHK_WRAP_CNT_EN
    logic wrap_evt;

    // An expectation of 1 in LOCK can only come from stepping past 255.
    assign wrap_evt = en && (state == LOCK) && hit && (exp_o == nxt(MAX_ODD));

    sat_cnt #(.W(8)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wrap_evt),
        .cnt (wrap_cnt_o)
    );
`endif

endmodule

// File: tb/tb_odd_seq_checker.sv
// tb/tb_odd_seq_checker.sv - directed self-checking bench for odd_seq_checker
module tb_odd_seq_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  cnt_i = 8'd0;
    logic        clr = 1'b0;

    logic        locked, err, sticky;
    logic [15:0] err_cnt;
    logic [7:0]  exp_v;
    logic        locked2, err2, sticky2;
    logic [1:0]  err_cnt2;
    logic [7:0]  exp2;
`ifdef ODD_CHK_WRAP_CNT_EN
    logic [7:0]  wrap_cnt, wrap_cnt2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    odd_seq_checker #(.LOCK_N(4), .MISS_MAX(3), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt_i(cnt_i), .clr(clr),
        .locked_o(locked), .err_o(err), .sticky_err_o(sticky), .err_cnt_o(err_cnt),
`ifdef ODD_CHK_WRAP_CNT_EN
        .wrap_cnt_o(wrap_cnt),
`endif
        .exp_o(exp_v)
    );

    odd_seq_checker #(.LOCK_N(4), .MISS_MAX(3), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cnt_i(cnt_i), .clr(clr),
        .locked_o(locked2), .err_o(err2), .sticky_err_o(sticky2), .err_cnt_o(err_cnt2),
`ifdef ODD_CHK_WRAP_CNT_EN
        .wrap_cnt_o(wrap_cnt2),
`endif
        .exp_o(exp2)
    );

    task automatic drive(input logic e, input logic [7:0] v, input logic c);
        en = e;
        cnt_i = v;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_from(input logic [7:0] start);
        logic [7:0] v;
        v = start;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, v, 1'b0);
            v = v + 8'd2;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({locked, err, sticky, err_cnt, exp_v} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got locked=%0b err=%0b sticky=%0b err_cnt=%0d exp=%0d required all 0",
                     locked, err, sticky, err_cnt, exp_v);
        end
    endtask

    task automatic test_basic_lock();
        do_reset();
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b1, 8'd3, 1'b0);
        drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd7, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early: got locked=%0b required 0", locked);
        end
        drive(1'b1, 8'd9, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd0 || exp_v !== 8'd11) begin
            failures++;
            $display("FAIL basic_lock: got locked=%0b err_cnt=%0d exp=%0d required 1/0/11", locked, err_cnt, exp_v);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [5];
        seq = '{8'd251, 8'd253, 8'd255, 8'd1, 8'd3};
        do_reset();
        lock_from(8'd241);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            checks++;
            if (err !== 1'b0 || locked !== 1'b1) begin
                failures++;
                $display("FAIL wrap_step%0d: got err=%0b locked=%0b required 0/1", i, err, locked);
            end
        end
        checks++;
        if (exp_v !== 8'd5 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL wrap_end: got exp=%0d err_cnt=%0d required 5/0", exp_v, err_cnt);
        end
`ifdef ODD_CHK_WRAP_CNT_EN
        checks++;
        if (wrap_cnt !== 8'd1) begin
            failures++;
            $display("FAIL wrap_cnt: got %0d required 1", wrap_cnt);
        end
`endif
    endtask

    task automatic test_glitch();
        do_reset();
        lock_from(8'd11);
        drive(1'b1, 8'd22, 1'b0);
        checks++;
        if (err !== 1'b1 || err_cnt !== 16'd1 || sticky !== 1'b1 || locked !== 1'b1 || exp_v !== 8'd23) begin
            failures++;
            $display("FAIL glitch_bad: got err=%0b err_cnt=%0d sticky=%0b locked=%0b exp=%0d required 1/1/1/1/23",
                     err, err_cnt, sticky, locked, exp_v);
        end
        drive(1'b1, 8'd23, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== 1'b1 || exp_v !== 8'd25 || sticky !== 1'b1) begin
            failures++;
            $display("FAIL glitch_recover: got err=%0b locked=%0b exp=%0d sticky=%0b required 0/1/25/1",
                     err, locked, exp_v, sticky);
        end
        // Two more bad samples must not drop lock if the 23 cleared the miss count.
        drive(1'b1, 8'd100, 1'b0);
        drive(1'b1, 8'd100, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd3 || exp_v !== 8'd29) begin
            failures++;
            $display("FAIL glitch_miss_cleared: got locked=%0b err_cnt=%0d exp=%0d required 1/3/29", locked, err_cnt, exp_v);
        end
    endtask

    task automatic test_lock_loss();
        logic [2:0] lk_exp [3];
        lk_exp = '{3'd1, 3'd1, 3'd0};
        do_reset();
        lock_from(8'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd100, 1'b0);
            checks++;
            if (err !== 1'b1 || err_cnt !== 16'(i + 1) || locked !== lk_exp[i][0]) begin
                failures++;
                $display("FAIL loss_bad%0d: got err=%0b err_cnt=%0d locked=%0b required 1/%0d/%0b",
                         i, err, err_cnt, locked, i + 1, lk_exp[i][0]);
            end
        end
        drive(1'b1, 8'd2, 1'b0);
        drive(1'b1, 8'd4, 1'b0);
        checks++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd3 || exp_v !== 8'd17) begin
            failures++;
            $display("FAIL loss_idle: got locked=%0b err=%0b err_cnt=%0d exp=%0d required 0/0/3/17",
                     locked, err, err_cnt, exp_v);
        end
        drive(1'b1, 8'd7, 1'b0);
        checks++;
        if (exp_v !== 8'd9 || locked !== 1'b0) begin
            failures++;
            $display("FAIL loss_reacq: got exp=%0d locked=%0b required 9/0", exp_v, locked);
        end
    endtask

    task automatic test_saturation_clr();
        do_reset();
        lock_from(8'd1);
        drive(1'b1, 8'd0, 1'b0);
        drive(1'b1, 8'd0, 1'b0);
        drive(1'b1, 8'd15, 1'b0);
        drive(1'b1, 8'd0, 1'b0);
        checks++;
        if (err_cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL sat_reach: got err_cnt=%0d required 3", err_cnt2);
        end
        drive(1'b1, 8'd0, 1'b0);
        drive(1'b1, 8'd21, 1'b0);
        drive(1'b1, 8'd0, 1'b0);
        checks++;
        if (err_cnt2 !== 2'd3 || err_cnt !== 16'd5 || locked2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got err_cnt2=%0d err_cnt=%0d locked2=%0b required 3/5/1", err_cnt2, err_cnt, locked2);
        end
        drive(1'b1, 8'd0, 1'b1);
        checks++;
        if (err_cnt2 !== 2'd1 || sticky2 !== 1'b1 || err_cnt !== 16'd1 || err2 !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_err: got err_cnt2=%0d sticky2=%0b err_cnt=%0d err2=%0b required 1/1/1/1",
                     err_cnt2, sticky2, err_cnt, err2);
        end
        drive(1'b1, 8'd27, 1'b1);
        checks++;
        if (err_cnt2 !== 2'd0 || sticky2 !== 1'b0 || locked2 !== 1'b1 || exp2 !== 8'd29) begin
            failures++;
            $display("FAIL clr_only: got err_cnt2=%0d sticky2=%0b locked2=%0b exp2=%0d required 0/0/1/29",
                     err_cnt2, sticky2, locked2, exp2);
        end
    endtask

    task automatic test_async_reset_and_gaps();
        do_reset();
        lock_from(8'd1);
        drive(1'b1, 8'd50, 1'b0);
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({locked, sticky, err_cnt, exp_v} !== 26'd0 || {locked2, sticky2, err_cnt2} !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: got locked=%0b sticky=%0b err_cnt=%0d exp=%0d required all 0",
                     locked, sticky, err_cnt, exp_v);
        end
        #1;
        rst = 1'b0;
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b0, 8'd100, 1'b0);
        checks++;
        if (err !== 1'b0 || exp_v !== 8'd3) begin
            failures++;
            $display("FAIL gap_hold: got err=%0b exp=%0d required 0/3", err, exp_v);
        end
        drive(1'b1, 8'd3, 1'b0);
        drive(1'b0, 8'd200, 1'b0);
        drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd7, 1'b0);
        drive(1'b1, 8'd9, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd0 || sticky !== 1'b0 || exp_v !== 8'd11) begin
            failures++;
            $display("FAIL gap_lock: got locked=%0b err_cnt=%0d sticky=%0b exp=%0d required 1/0/0/11",
                     locked, err_cnt, sticky, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_wrap();
        test_glitch();
        test_lock_loss();
        test_saturation_clr();
        test_async_reset_and_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
